// File: rtl/multwrap_rd_ctrl_pkg.sv
// Shared types and default step counts for the multi-matmul wrapper read sequencer.
`timescale 1ns/1ps
package multwrap_rd_ctrl_pkg;

   localparam int INNER_DIMENSION   = 32;
   localparam int B_OUTER_DIMENSION = 16;
   localparam int BLOCK_SIZE        = 4;
   localparam int NUM_CORES_B       = 2;
   localparam int TOTAL_MODULES     = 2;

   // Weight words per output block, and output column blocks per pass.
   localparam int INNER_STEPS_DEF  = INNER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B);
   localparam int OUTER_STEPS_DEF  = B_OUTER_DIMENSION / (BLOCK_SIZE * TOTAL_MODULES);
   localparam int ADDR_WIDTH_B_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ISSUE,
      DRAIN,
      WAIT_ACC,
      FINISH
   } rd_ctrl_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multwrap_rd_ctrl_if.sv
// Control/handshake bundle between the read sequencer and the wrapper/MHA control.
`timescale 1ns/1ps
interface multwrap_rd_ctrl_if #(
   parameter int ADDR_WIDTH_B = 4,
   parameter int IDX_W        = 1
);
   logic                    start;
   logic                    in_valid;
   logic                    in_ready;
   logic                    w_mat_enb;
   logic [ADDR_WIDTH_B-1:0] w_mat_addrb;
   logic                    en_module;
   logic                    internal_reset_acc;
   logic                    acc_done_wrap;
   logic                    blk_done;
   logic [IDX_W-1:0]        blk_idx;
   logic                    busy;
   logic                    done;
   logic                    err_acc;

   modport master (
      input  start, in_valid, acc_done_wrap,
      output in_ready, w_mat_enb, w_mat_addrb, en_module, internal_reset_acc,
             blk_done, blk_idx, busy, done, err_acc
   );

   modport slave (
      output start, in_valid, acc_done_wrap,
      input  in_ready, w_mat_enb, w_mat_addrb, en_module, internal_reset_acc,
             blk_done, blk_idx, busy, done, err_acc
   );
endinterface

// File: rtl/multwrap_rd_ctrl.sv
// Walks weight BRAM port B block by block, pacing the A stream; first read 2 cycles after start.
// Backpressure: in_ready only in ISSUE, stalls of any length hold the address; WAIT_ACC waits indefinitely.
`timescale 1ns/1ps
module multwrap_rd_ctrl
   import multwrap_rd_ctrl_pkg::*;
#(
   parameter int INNER_STEPS  = INNER_STEPS_DEF,
   parameter int OUTER_STEPS  = OUTER_STEPS_DEF,
   parameter int ADDR_WIDTH_B = ADDR_WIDTH_B_DEF,
   parameter int BRAM_RD_LAT  = 1
) (
   input  logic clk,
   input  logic rst_n,
   multwrap_rd_ctrl_if.master bus
);

   localparam int                IDX_W      = idx_width(OUTER_STEPS);
   localparam logic [ADDR_WIDTH_B-1:0] STEP       = ADDR_WIDTH_B'(INNER_STEPS);
   localparam logic [ADDR_WIDTH_B-1:0] LAST_INNER = ADDR_WIDTH_B'(INNER_STEPS - 1);
   localparam logic [ADDR_WIDTH_B-1:0] LAST_OUTER = ADDR_WIDTH_B'(OUTER_STEPS - 1);

   if (BRAM_RD_LAT != 1) begin : g_bad_lat
      $error("multwrap_rd_ctrl: only BRAM_RD_LAT=1 is supported");
   end
   if (INNER_STEPS < 1 || OUTER_STEPS < 1 ||
       INNER_STEPS * OUTER_STEPS > (1 << ADDR_WIDTH_B)) begin : g_bad_steps
      $error("multwrap_rd_ctrl: step counts do not fit the port-B address space");
   end

   rd_ctrl_state_t          r_state;
   rd_ctrl_state_t          w_state_nxt;
   logic [ADDR_WIDTH_B-1:0] r_inner;
   logic [ADDR_WIDTH_B-1:0] r_outer;
   logic [ADDR_WIDTH_B-1:0] r_addr_last;
   logic [ADDR_WIDTH_B-1:0] w_addr_cur;
   logic                    r_en_module;
   logic                    r_err_acc;
   logic                    w_in_ready;
   logic                    w_beat;
   logic                    w_blk_done;
   logic                    w_last_inner;
   logic                    w_last_outer;

   assign w_addr_cur   = r_outer * STEP + r_inner;
   assign w_last_inner = (r_inner == LAST_INNER);
   assign w_last_outer = (r_outer == LAST_OUTER);
   assign w_beat       = w_in_ready & bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_blk_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = CLEAR;
         end
         CLEAR: begin
            w_state_nxt = ISSUE;
         end
         ISSUE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid && w_last_inner) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            w_state_nxt = WAIT_ACC;
         end
         WAIT_ACC: begin
            if (bus.acc_done_wrap) begin
               w_blk_done  = 1'b1;
               w_state_nxt = w_last_outer ? FINISH : CLEAR;
            end
         end
         FINISH: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inner     <= '0;
         r_outer     <= '0;
         r_addr_last <= '0;
         r_en_module <= 1'b0;
         r_err_acc   <= 1'b0;
      end else begin
         // en_module lines up with doutb of the single-cycle-latency BRAM
         r_en_module <= w_beat;
         if (r_state == IDLE && bus.start) r_outer <= '0;
         if (r_state == CLEAR) r_inner <= '0;
         if (w_beat) begin
            r_inner     <= r_inner + 1'b1;
            r_addr_last <= w_addr_cur;
         end
         if (w_blk_done && !w_last_outer) r_outer <= r_outer + 1'b1;
         if (bus.acc_done_wrap && r_state != WAIT_ACC) r_err_acc <= 1'b1;
      end
   end

   assign bus.in_ready           = w_in_ready;
   assign bus.w_mat_enb          = w_beat;
   assign bus.w_mat_addrb        = w_beat ? w_addr_cur : r_addr_last;
   assign bus.en_module          = r_en_module;
   assign bus.internal_reset_acc = (r_state == CLEAR);
   assign bus.blk_done           = w_blk_done;
   assign bus.blk_idx            = w_blk_done ? r_outer[IDX_W-1:0] : '0;
   assign bus.busy               = (r_state != IDLE);
   assign bus.done               = (r_state == FINISH);
   assign bus.err_acc            = r_err_acc;

endmodule

// File: tb/tb_multwrap_rd_ctrl.sv
// Bench for multwrap_rd_ctrl: cycle tables for fixed timelines, address scoreboard for reactive passes.
`timescale 1ns/1ps
module tb_multwrap_rd_ctrl;

   typedef struct packed {
      logic       ir;
      logic       enb;
      logic [3:0] addr;
      logic       en;
      logic       racc;
      logic       bd;
      logic       idx;
      logic       busy;
      logic       done;
      logic       err;
   } outs_t;

   typedef struct {
      logic  st;
      logic  iv;
      logic  acc;
      outs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multwrap_rd_ctrl_if #(.ADDR_WIDTH_B(4), .IDX_W(1)) a_if ();
   multwrap_rd_ctrl_if #(.ADDR_WIDTH_B(4), .IDX_W(1)) b_if ();

   multwrap_rd_ctrl #(.INNER_STEPS(4), .OUTER_STEPS(2), .ADDR_WIDTH_B(4), .BRAM_RD_LAT(1))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   multwrap_rd_ctrl #(.INNER_STEPS(1), .OUTER_STEPS(1), .ADDR_WIDTH_B(4), .BRAM_RD_LAT(1))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl[$];
   int   a_q[$];
   int   a_last_addr = 0;
   logic a_prev_enb  = 1'b0;
   int   a_blk_exp, a_blk_cnt, a_done_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, iv, acc, ir, enb, input logic [3:0] addr,
                               input logic en, racc, bd, idx, busy, done, err);
      vec_t v;
      v.st  = st; v.iv = iv; v.acc = acc;
      v.exp = '{ir, enb, addr, en, racc, bd, idx, busy, done, err};
      return v;
   endfunction

   function automatic outs_t get_a();
      return '{a_if.in_ready, a_if.w_mat_enb, a_if.w_mat_addrb, a_if.en_module,
               a_if.internal_reset_acc, a_if.blk_done, a_if.blk_idx[0], a_if.busy,
               a_if.done, a_if.err_acc};
   endfunction

   function automatic outs_t get_b();
      return '{b_if.in_ready, b_if.w_mat_enb, b_if.w_mat_addrb, b_if.en_module,
               b_if.internal_reset_acc, b_if.blk_done, b_if.blk_idx[0], b_if.busy,
               b_if.done, b_if.err_acc};
   endfunction

   task automatic mon_a(input bit sb);
      int exp_addr;
      exp_addr = a_last_addr;
      if (sb) begin
         chk("en_module_delay", a_if.en_module, a_prev_enb);
         if (a_if.w_mat_enb) begin
            chk("enb_needs_valid", a_if.in_valid, 1);
            if (a_q.size() == 0) chk("sb_extra_beat", 1, 0);
            else begin
               exp_addr = a_q.pop_front();
               chk("addrb_seq", a_if.w_mat_addrb, exp_addr);
            end
         end else begin
            chk("addrb_hold", a_if.w_mat_addrb, a_last_addr);
         end
         if (a_if.blk_done) begin
            chk("blk_idx", a_if.blk_idx, a_blk_exp);
            a_blk_exp++;
            a_blk_cnt++;
         end
         if (a_if.done) a_done_cnt++;
      end else if (a_if.w_mat_enb) begin
         exp_addr = int'(a_if.w_mat_addrb);
      end
      a_last_addr = exp_addr;
      a_prev_enb  = a_if.w_mat_enb;
   endtask

   task automatic cyc_a(input logic st, iv, acc, input bit sb);
      @(negedge clk);
      a_if.start = st; a_if.in_valid = iv; a_if.acc_done_wrap = acc;
      #2;
      mon_a(sb);
   endtask

   task automatic run_tbl_a(input string nm);
      foreach (tbl[i]) begin
         @(negedge clk);
         a_if.start = tbl[i].st; a_if.in_valid = tbl[i].iv; a_if.acc_done_wrap = tbl[i].acc;
         #2;
         chk($sformatf("%s[%0d]", nm, i), get_a(), tbl[i].exp);
         mon_a(0);
      end
      tbl.delete();
   endtask

   task automatic run_tbl_b(input string nm);
      foreach (tbl[i]) begin
         @(negedge clk);
         b_if.start = tbl[i].st; b_if.in_valid = tbl[i].iv; b_if.acc_done_wrap = tbl[i].acc;
         #2;
         chk($sformatf("%s[%0d]", nm, i), get_b(), tbl[i].exp);
      end
      tbl.delete();
   endtask

   // Full reactive pass on dut_a: acc_done arrives on the WAIT_ACC entry cycle.
   task automatic pass_a(input bit spam_start, input bit acc_in_issue);
      int   beats, cnt_down;
      bit   fin, pulsed;
      logic acc;
      a_q.delete();
      for (int i = 0; i < 8; i++) a_q.push_back(i);
      a_blk_exp = 0; a_blk_cnt = 0; a_done_cnt = 0;
      beats = 0; cnt_down = -1; fin = 0; pulsed = 0;
      cyc_a(1, 1, 0, 1);
      for (int c = 0; c < 100 && !fin; c++) begin
         acc = (cnt_down == 0);
         if (acc_in_issue && beats == 1 && !pulsed) begin
            acc    = 1'b1;
            pulsed = 1'b1;
         end
         cyc_a(spam_start, 1, acc, 1);
         if (cnt_down >= 0) cnt_down--;
         if (a_if.in_valid && a_if.in_ready) begin
            beats++;
            if (beats % 4 == 0) cnt_down = 1;
         end
         if (a_if.done) fin = 1;
      end
      if (!fin) chk("pass_timeout", 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc_a(0, 0, 0, 1);
         chk("idle_after_pass", a_if.busy, 0);
      end
      chk("done_count", a_done_cnt, 1);
      chk("blk_count", a_blk_cnt, 2);
      chk("sb_leftover", a_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      rst_n = 1'b0;
      a_if.start = 0; a_if.in_valid = 0; a_if.acc_done_wrap = 0;
      b_if.start = 0; b_if.in_valid = 0; b_if.acc_done_wrap = 0;
      repeat (2) @(negedge clk);
      #2;
      chk("reset_outs_a", get_a(), '0);
      chk("reset_outs_b", get_b(), '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Nominal pass, in_valid held high, acc_done 3 cycles after DRAIN.
      //            st iv acc  ir enb addr en racc bd idx busy done err
      tbl.push_back(mk(1, 1, 0,  0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd1, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd2, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd3, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd3, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd3, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd3, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1,  0, 0, 4'd3, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd3, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd4, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd5, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd6, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd7, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd7, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd7, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd7, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1,  0, 0, 4'd7, 0, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd7, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd7, 0, 0, 0, 0, 0, 0, 0));
      run_tbl_a("nominal");

      // Stalled ISSUE (1,0,0,1,1,0,1); acc_done on the WAIT_ACC entry cycle.
      tbl.push_back(mk(1, 0, 0,  0, 0, 4'd7, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4'd7, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 0, 4'd0, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd2, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  1, 0, 4'd2, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd3, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd3, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1,  0, 0, 4'd3, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd3, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd4, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd5, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd6, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd7, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd7, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1,  0, 0, 4'd7, 0, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4'd7, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4'd7, 0, 0, 0, 0, 0, 0, 0));
      run_tbl_a("stall");

      // start held high through the whole pass, including FINISH.
      pass_a(1, 0);
      chk("err_clear_before", a_if.err_acc, 0);

      // acc_done outside WAIT_ACC: in IDLE, then mid-ISSUE of a pass.
      cyc_a(0, 0, 1, 1);
      cyc_a(0, 0, 0, 1);
      chk("err_set_idle", a_if.err_acc, 1);
      pass_a(0, 1);
      chk("err_sticky", a_if.err_acc, 1);

      // Async reset with inner==2, then a clean pass from address 0.
      a_q.delete();
      for (int i = 0; i < 8; i++) a_q.push_back(i);
      cyc_a(1, 0, 0, 1);
      beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
         cyc_a(0, 1, 0, 1);
         if (a_if.in_valid && a_if.in_ready) beats++;
      end
      chk("beats_before_reset", beats, 2);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk("reset_midpass_async", get_a(), '0);
      @(posedge clk);
      #1 chk("reset_midpass_held", get_a(), '0);
      a_if.in_valid = 1'b0;
      @(negedge clk);
      rst_n       = 1'b1;
      a_last_addr = 0;
      a_prev_enb  = 1'b0;
      pass_a(0, 0);

      // INNER_STEPS=1, OUTER_STEPS=1 on dut_b.
      tbl.push_back(mk(1, 0, 0,  0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  1, 1, 4'd0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 0,  0, 0, 4'd0, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4'd0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1,  0, 0, 4'd0, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4'd0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,  0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0));
      run_tbl_b("single");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multwrap_rd_ctrl.md
Name: multwrap_rd_ctrl

Overview:
- Read-side sequencer for the weight-BRAM + multi-matmul wrapper.
- Drives the wrapper's BRAM port-B read (w_mat_enb, w_mat_addrb), the module enable and the accumulator clear.
- Walks every outer column block of the weight matrix across all inner-dimension chunks, and paces the A-side input stream with a valid/ready handshake.
- Reports each finished output block and overall completion to the Multi-Head Attention top-level control.

Parameters:
- INNER_STEPS, 4: weight words per output block (INNER_DIMENSION / (BLOCK_SIZE*NUM_CORES_B) chunking); range 1..2^ADDR_WIDTH_B.
- OUTER_STEPS, 2: output column blocks per pass; INNER_STEPS*OUTER_STEPS ≤ 2^ADDR_WIDTH_B.
- ADDR_WIDTH_B, 4: BRAM port-B address width; must match the wrapper.
- BRAM_RD_LAT, 1: BRAM read latency in cycles; only 1 is supported (elaboration error otherwise).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pass request; ignored while busy.
- in_valid, in, 1: A-side beat available.
- in_ready, out, 1: this block accepts an A-side beat this cycle.
- w_mat_enb, out, 1: BRAM port-B read enable.
- w_mat_addrb, out, ADDR_WIDTH_B: BRAM port-B address.
- en_module, out, 1: wrapper compute enable, aligned with BRAM doutb.
- internal_reset_acc, out, 1: wrapper accumulator clear.
- acc_done_wrap, in, 1: wrapper reports block accumulation finished.
- blk_done, out, 1: one-cycle pulse, output block ready at wrapper output.
- blk_idx, out, $clog2(OUTER_STEPS) (min 1): index of the finished block, valid with blk_done.
- busy, out, 1: pass in progress.
- done, out, 1: one-cycle pulse at end of pass.
- err_acc, out, 1: sticky; acc_done_wrap seen outside WAIT_ACC. Cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, CLEAR, ISSUE, DRAIN, WAIT_ACC, FINISH.
- IDLE: on start go to CLEAR with outer=0 and busy=1 from the next cycle.
- CLEAR (1 cycle):
  - internal_reset_acc=1.
  - inner=0.
  - Next state ISSUE.
- ISSUE:
  - in_ready=1.
  - Beat = in_valid & in_ready.
  - On a beat: w_mat_enb=1 and w_mat_addrb = outer*INNER_STEPS + inner (combinational from registered counters), and inner increments.
  - No beat: w_mat_enb=0 and the address holds its last value. Stalls of any length are legal.
  - After the beat with inner==INNER_STEPS-1, go to DRAIN.
- en_module: registered copy of the beat (1-cycle delay = BRAM_RD_LAT), so the wrapper sees doutb and the matching A data on the same cycle. Upstream must present A data aligned to en_module, i.e. one cycle after its accepted handshake.
- DRAIN (1 cycle):
  - in_ready=0 and w_mat_enb=0.
  - The last en_module pulse fires here.
  - Next state WAIT_ACC.
- WAIT_ACC:
  - Waits on acc_done_wrap with no timeout.
  - On acc_done_wrap: blk_done=1 and blk_idx=outer for 1 cycle.
  - If outer==OUTER_STEPS-1 go to FINISH; otherwise outer++ and go to CLEAR.
  - acc_done_wrap coincident with entry into WAIT_ACC is accepted on that cycle.
- FINISH (1 cycle):
  - done=1.
  - busy goes low on the next cycle.
  - Next state IDLE.
- A start arriving in FINISH is ignored; start must be reissued once in IDLE.
- Boundary cases:
  - INNER_STEPS=1: ISSUE lasts exactly one beat.
  - OUTER_STEPS=1: blk_idx is fixed at 0.
  - The address never wraps within a pass; the maximum address is INNER_STEPS*OUTER_STEPS-1.
- Async reset mid-pass returns to IDLE immediately with all outputs 0. No partial-result signalling.
- Nominal latency with no stalls, start to first w_mat_enb: 2 cycles (IDLE→CLEAR→ISSUE).

Decomposition:
- Add to linear_proj_pkg:
  - typedef enum logic [2:0] rd_ctrl_state_t {IDLE, CLEAR, ISSUE, DRAIN, WAIT_ACC, FINISH}.
  - localparams INNER_STEPS_DEF and OUTER_STEPS_DEF derived from INNER_DIMENSION, B_OUTER_DIMENSION, BLOCK_SIZE, NUM_CORES_B and TOTAL_MODULES.
- Single module; no sub-module is needed. Address and counter logic stay inline.

Test Plan:
- INNER_STEPS=4, OUTER_STEPS=2, in_valid always 1, acc_done_wrap 3 cycles after DRAIN:
  - w_mat_addrb sequence 0,1,2,3 then 4,5,6,7, with w_mat_enb high only on those cycles.
  - en_module is the same pattern delayed 1 cycle.
  - internal_reset_acc pulses twice.
  - blk_done with blk_idx 0 then 1.
  - done exactly once.
- in_valid toggling 1,0,0,1,1,0,1 in ISSUE: addresses advance only on the high cycles (0,1,2,3 over 7 cycles); addrb is stable during stalls; en_module tracks beats +1.
- start pulsed while busy and again in the FINISH cycle: no second pass, the counters are not disturbed, done fires once.
- acc_done_wrap pulsed in IDLE and during ISSUE: err_acc=1 and stays set; the sequence continues unaffected.
- rst_n asserted in ISSUE at inner=2: all outputs are 0 immediately. After release, start gives a clean pass from address 0.
- INNER_STEPS=1, OUTER_STEPS=1: CLEAR, one beat at address 0, DRAIN, WAIT_ACC, then blk_done with blk_idx 0 and done on the next cycle.
